// File: rtl/redmule_z_buffer.sv
// Z staging buffer: captures one engine result column per fill cycle into a
// Height x Width tile, then drains it row by row to the Z streamer.
module redmule_z_buffer #(
    parameter int unsigned Height = 4,
    parameter int unsigned Width  = 8,
    parameter int unsigned BITW   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         clk_en_i,
    input  logic                         fill_i,
    input  logic [Height*BITW-1:0]       res_i,
    input  logic [$clog2(Height):0]      rows_i,
    input  logic [$clog2(Width):0]       cols_i,
    input  logic                         store_i,
    output logic [Width*BITW-1:0]        z_data_o,
    output logic [Width*BITW/8-1:0]      z_strb_o,
    output logic                         z_valid_o,
    input  logic                         z_ready_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         overflow_o,
    output logic                         busy_o
);

    localparam int unsigned RW  = (Height > 1) ? $clog2(Height) : 1;
    localparam int unsigned CW  = (Width > 1) ? $clog2(Width) : 1;
    localparam int unsigned RIW = $clog2(Height) + 1;
    localparam int unsigned CIW = $clog2(Width) + 1;
    localparam int unsigned BPE = BITW / 8;

    typedef enum logic [1:0] {
        FILL,
        FULL,
        DRAIN
    } state_e;

    state_e          state, state_next;
    logic [BITW-1:0] mem [Height][Width];
    logic [CW-1:0]   fill_cnt;
    logic [RW-1:0]   row_cnt;
    logic [RW-1:0]   last_row, last_row_next;
    logic [CIW-1:0]  eff_cols, eff_cols_next;
    logic            overflow;
    logic            fill_fire, fill_last, row_last, handshake;

    assign fill_fire  = fill_i & clk_en_i;
    assign fill_last  = (fill_cnt == CW'(Width - 1));
    assign row_last   = (row_cnt == last_row);
    assign handshake  = (state == DRAIN) && z_ready_i;
    assign overflow_o = overflow;
    assign busy_o     = (state != FILL) || (fill_cnt != '0);

    // Clamp requested row/column counts: zero or out-of-range means the full tile.
    always_comb begin
        if (rows_i == '0 || rows_i > RIW'(Height)) begin
            last_row_next = RW'(Height - 1);
        end else begin
            last_row_next = RW'(rows_i - RIW'(1));
        end
        if (cols_i == '0 || cols_i > CIW'(Width)) begin
            eff_cols_next = CIW'(Width);
        end else begin
            eff_cols_next = cols_i;
        end
    end

    // State register; soft clear returns to FILL.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= FILL;
        end else if (clear_i) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/output decode; drain data is a mux of stored rows.
    always_comb begin
        state_next = state;
        full_o     = 1'b0;
        z_valid_o  = 1'b0;
        empty_o    = 1'b0;
        z_data_o   = '0;
        z_strb_o   = '0;
        unique case (state)
            FILL: begin
                if (fill_fire && fill_last) state_next = FULL;
            end
            FULL: begin
                full_o = 1'b1;
                if (store_i) state_next = DRAIN;
            end
            DRAIN: begin
                full_o    = 1'b1;
                z_valid_o = 1'b1;
                for (int unsigned c = 0; c < Width; c++) begin
                    z_data_o[c*BITW +: BITW] = mem[row_cnt][c];
                    if (CIW'(c) < eff_cols) z_strb_o[c*BPE +: BPE] = '1;
                end
                if (z_ready_i && row_last) begin
                    empty_o    = !clear_i;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Tile storage, fill/row counters, latched drain geometry and sticky overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fill_cnt <= '0;
            row_cnt  <= '0;
            last_row <= '0;
            eff_cols <= '0;
            overflow <= 1'b0;
            for (int unsigned r = 0; r < Height; r++)
                for (int unsigned c = 0; c < Width; c++)
                    mem[r][c] <= '0;
        end else if (clear_i) begin
            fill_cnt <= '0;
            row_cnt  <= '0;
            last_row <= '0;
            eff_cols <= '0;
            overflow <= 1'b0;
            for (int unsigned r = 0; r < Height; r++)
                for (int unsigned c = 0; c < Width; c++)
                    mem[r][c] <= '0;
        end else begin
            if (fill_fire) begin
                if (state == FILL) begin
                    for (int unsigned r = 0; r < Height; r++)
                        mem[r][fill_cnt] <= res_i[r*BITW +: BITW];
                    fill_cnt <= fill_last ? '0 : fill_cnt + CW'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (state == FULL && store_i) begin
                last_row <= last_row_next;
                eff_cols <= eff_cols_next;
                row_cnt  <= '0;
            end
            if (handshake) begin
                row_cnt <= row_last ? '0 : row_cnt + RW'(1);
            end
        end
    end

endmodule

// File: tb/tb_redmule_z_buffer.sv
// Self-checking bench for redmule_z_buffer: fills tiles from a bench-side
// model, queues the expected drain beats and compares them at each handshake.
module tb_redmule_z_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         clk_en;
    logic         fill;
    logic [63:0]  res;
    logic [2:0]   rows_in;
    logic [3:0]   cols_in;
    logic         store;
    logic [127:0] z_data;
    logic [15:0]  z_strb;
    logic         z_valid;
    logic         z_ready;
    logic         full;
    logic         empty;
    logic         overflow;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    int empty_cnt = 0;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  strb;
        logic         last;
    } beat_t;

    beat_t        sb[$];
    beat_t        b;
    logic [15:0]  mdl [4][8];
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data  = '0;

    always #5 clk = ~clk;

    redmule_z_buffer #(
        .Height (4),
        .Width  (8),
        .BITW   (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clear_i    (clear),
        .clk_en_i   (clk_en),
        .fill_i     (fill),
        .res_i      (res),
        .rows_i     (rows_in),
        .cols_i     (cols_in),
        .store_i    (store),
        .z_data_o   (z_data),
        .z_strb_o   (z_strb),
        .z_valid_o  (z_valid),
        .z_ready_i  (z_ready),
        .full_o     (full),
        .empty_o    (empty),
        .overflow_o (overflow),
        .busy_o     (busy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (empty) empty_cnt++;
            if (z_valid && prev_stall) check("stall_data", z_data, prev_data);
            if (z_valid && z_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    check("unexp_beat", 128'(z_valid & z_ready), 128'(0));
                end else begin
                    b = sb.pop_front();
                    check("row_data", z_data, b.data);
                    check("row_strb", 128'(z_strb), 128'(b.strb));
                    check("row_empty", 128'(empty), 128'(b.last));
                end
            end else if (empty) begin
                check("empty_spurious", 128'(empty), 128'(0));
            end
            prev_stall = z_valid && !z_ready;
            prev_data  = z_data;
        end
    end

    task automatic fill_tile(input int tile, input int ncols, input bit interleave);
        for (int c = 0; c < ncols; c++) begin
            if (interleave) begin
                fill = 1'b1; clk_en = 1'b0; res = '1;
                @(posedge clk); #1;
                check("full_ignored", 128'(full), 128'(0));
            end
            fill = 1'b1; clk_en = 1'b1;
            for (int r = 0; r < 4; r++) begin
                mdl[r][c] = 16'(tile * 256 + c * 16 + r);
                res[r*16 +: 16] = mdl[r][c];
            end
            @(posedge clk); #1;
            check("full_fill", 128'(full), 128'(c == 7));
        end
        fill = 1'b0; clk_en = 1'b0;
    endtask

    task automatic drain(input int rows, input int cols, input bit bp, input bit ovf_fill);
        int er, ec, hs0, e0;
        bit done;
        beat_t nb;
        er = (rows == 0 || rows > 4) ? 4 : rows;
        ec = (cols == 0 || cols > 8) ? 8 : cols;
        for (int r = 0; r < er; r++) begin
            nb.data = '0;
            nb.strb = '0;
            for (int c = 0; c < 8; c++) nb.data[c*16 +: 16] = mdl[r][c];
            for (int c = 0; c < ec; c++) nb.strb[2*c +: 2] = 2'b11;
            nb.last = (r == er - 1);
            sb.push_back(nb);
        end
        hs0 = hs_cnt; e0 = empty_cnt; done = 1'b0;
        rows_in = 3'(rows); cols_in = 4'(cols); store = 1'b1;
        @(posedge clk); #1;
        store = 1'b0;
        check("valid_drain", 128'(z_valid), 128'(1));
        rows_in = 3'd4; cols_in = 4'd0;
        for (int k = 0; k < 40 && !done; k++) begin
            z_ready = bp ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
            if (ovf_fill && k == 1) begin
                fill = 1'b1; clk_en = 1'b1; res = '1;
            end else begin
                fill = 1'b0; clk_en = 1'b0;
            end
            @(posedge clk); #1;
            if (empty_cnt != e0) done = 1'b1;
        end
        fill = 1'b0; clk_en = 1'b0; z_ready = 1'b0;
        check("drain_done", 128'(done), 128'(1));
        check("hs_count", 128'(hs_cnt - hs0), 128'(er));
        check("empty_count", 128'(empty_cnt - e0), 128'(1));
        check("full_after", 128'(full), 128'(0));
        check("sb_left", 128'(sb.size()), 128'(0));
        sb.delete();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; clk_en = 1'b0; fill = 1'b0; res = '0;
        rows_in = 3'd4; cols_in = 4'd8; store = 1'b0; z_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_full", 128'(full), 128'(0));
        check("rst_valid", 128'(z_valid), 128'(0));
        check("rst_empty", 128'(empty), 128'(0));
        check("rst_overflow", 128'(overflow), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_data", z_data, 128'(0));
        check("rst_strb", 128'(z_strb), 128'(0));

        store = 1'b1;
        @(posedge clk); #1;
        store = 1'b0;
        check("store_in_fill_valid", 128'(z_valid), 128'(0));
        check("store_in_fill_full", 128'(full), 128'(0));

        fill_tile(1, 8, 1'b0);
        check("busy_full", 128'(busy), 128'(1));
        drain(4, 8, 1'b0, 1'b0);

        fill_tile(2, 8, 1'b0);
        drain(4, 8, 1'b1, 1'b0);

        fill_tile(3, 8, 1'b0);
        drain(2, 3, 1'b0, 1'b0);

        fill_tile(4, 8, 1'b0);
        drain(4, 8, 1'b1, 1'b1);
        check("ovf_set", 128'(overflow), 128'(1));
        check("ovf_fillcnt", 128'(busy), 128'(0));
        @(posedge clk); #1;
        check("ovf_sticky", 128'(overflow), 128'(1));
        pulse_clear();
        check("clr_ovf", 128'(overflow), 128'(0));
        check("clr_busy", 128'(busy), 128'(0));
        check("clr_full", 128'(full), 128'(0));

        fill_tile(5, 8, 1'b1);
        drain(0, 0, 1'b0, 1'b0);

        fill_tile(6, 5, 1'b0);
        check("partial_busy", 128'(busy), 128'(1));
        check("partial_full", 128'(full), 128'(0));
        pulse_clear();
        check("midfill_clr_busy", 128'(busy), 128'(0));
        fill_tile(7, 8, 1'b0);
        drain(7, 15, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
